// File: rtl/selector_pkg.sv
// Shared definitions for the 4:1 selector scan controller.
//   CH_W    : width of a channel index
//   N_CH    : number of selector channels
//   state_t : scan FSM state encoding
package selector_pkg;

    localparam int unsigned CH_W = 2;
    localparam int unsigned N_CH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/sel_rr_next.sv
// Round-robin channel picker (combinational).
// Finds the next set bit of mask strictly above cur, wrapping 3->0; cur itself
// is the last candidate, so a single-bit mask re-selects the current channel.
//   cur  in   CH_W  current channel index
//   mask in   N_CH  enabled channels
//   nxt  out  CH_W  next channel index (holds cur when none is set)
//   none out  1     no bit of mask is set
module sel_rr_next
    import selector_pkg::*;
(
    input  logic [CH_W-1:0] cur,
    input  logic [N_CH-1:0] mask,
    output logic [CH_W-1:0] nxt,
    output logic            none
);

    // Scan offsets 1..N_CH; the 2-bit sum wraps naturally, offset N_CH lands on cur.
    always_comb begin
        nxt  = cur;
        none = 1'b1;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            if (none && mask[cur + CH_W'(i)]) begin
                nxt  = cur + CH_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/selector_scan_ctrl.sv
// Sequencer for the 4:1 selector: scans enabled channels round-robin with a
// blanking gap (en=1) after each switch and a programmable dwell (en=0), and
// emits one sampled dout bit per visited channel tagged with its index.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        pulse, begin scanning (IDLE only)
//   stop         pulse, end scan request (sticky until honoured)
//   ch_mask      channels included in the scan
//   dwell        en-low cycles per channel (0 treated as 1)
//   mux_dout     selector output
//   sel_1, sel_0 channel index to selector
//   en           selector enable, active-low
//   busy         scan in progress
//   sample_vld   1-cycle strobe for sample_bit/sample_ch
//   sample_bit   mux_dout captured on the last dwell cycle
//   sample_ch    channel of sample_bit
module selector_scan_ctrl
    import selector_pkg::*;
#(
    parameter int unsigned DWELL_W   = 8,
    parameter int unsigned BLANK_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [3:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_dout,
    output logic               sel_0,
    output logic               sel_1,
    output logic               en,
    output logic               busy,
    output logic               sample_vld,
    output logic               sample_bit,
    output logic [1:0]         sample_ch
);

    // Counter must hold both the dwell reload and BLANK_CYC-1 (up to 14).
    localparam int unsigned CNT_W = (DWELL_W > 4) ? DWELL_W : 4;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stop_q, stop_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              vld_q, vld_d;
    logic              bit_q, bit_d;
    logic [CH_W-1:0]   sch_q, sch_d;

    logic              stop_pend;
    logic              cnt_zero;
    logic [CNT_W-1:0]  dwell_ld;
    logic [CNT_W-1:0]  blank_ld;
    logic [CH_W-1:0]   rr_cur;
    logic [CH_W-1:0]   rr_nxt;
    logic              rr_none;

    assign stop_pend = stop_q | stop;
    assign cnt_zero  = (cnt_q == '0);
    assign dwell_ld  = (dwell == '0) ? '0 : (CNT_W'(dwell) - CNT_W'(1));
    assign blank_ld  = CNT_W'(BLANK_CYC - 1);

    // From IDLE search from index 3 so the lowest set bit is chosen first.
    assign rr_cur = (state_q == ST_IDLE) ? CH_W'(N_CH - 1) : ch_q;

    sel_rr_next u_rr (
        .cur  (rr_cur),
        .mask (ch_mask),
        .nxt  (rr_nxt),
        .none (rr_none)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            ch_q    <= '0;
            en_q    <= 1'b1;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            bit_q   <= 1'b0;
            sch_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            ch_q    <= ch_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
            bit_q   <= bit_d;
            sch_q   <= sch_d;
        end
    end

    // Next-state logic; stop is checked only at BLANK or at the end of a dwell.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !stop && !rr_none) state_d = ST_BLANK;
            end
            ST_BLANK: begin
                if (stop_pend)     state_d = ST_IDLE;
                else if (cnt_zero) state_d = ST_DWELL;
            end
            ST_DWELL: begin
                if (cnt_zero) state_d = (stop_pend || rr_none) ? ST_IDLE : ST_BLANK;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for counter, stop request and outputs.
    always_comb begin
        cnt_d  = cnt_q;
        stop_d = stop_q | stop;
        ch_d   = ch_q;
        en_d   = en_q;
        vld_d  = 1'b0;
        bit_d  = bit_q;
        sch_d  = sch_q;
        busy_d = (state_d != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                en_d   = 1'b1;
                if (state_d == ST_BLANK) begin
                    ch_d  = rr_nxt;
                    cnt_d = blank_ld;
                end
            end
            ST_BLANK: begin
                if (state_d == ST_IDLE) begin
                    stop_d = 1'b0;
                end else if (state_d == ST_DWELL) begin
                    en_d  = 1'b0;
                    cnt_d = dwell_ld;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DWELL: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Last dwell cycle: capture, then blank before any switch.
                    vld_d = 1'b1;
                    bit_d = mux_dout;
                    sch_d = ch_q;
                    en_d  = 1'b1;
                    if (state_d == ST_BLANK) begin
                        ch_d  = rr_nxt;
                        cnt_d = blank_ld;
                    end else begin
                        stop_d = 1'b0;
                    end
                end
            end
            default: begin
                en_d = 1'b1;
            end
        endcase
    end

    assign sel_0      = ch_q[0];
    assign sel_1      = ch_q[1];
    assign en         = en_q;
    assign busy       = busy_q;
    assign sample_vld = vld_q;
    assign sample_bit = bit_q;
    assign sample_ch  = sch_q;

endmodule

// File: tb/tb_selector_scan_ctrl.sv
// Bench for selector_scan_ctrl: directed scans with a behavioural 4:1 selector
// (dout = channel data bit while en=0) and a scoreboard of expected samples.
module tb_selector_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] ch_mask = 4'h0;
    logic [7:0] dwell = 8'd0;
    logic [3:0] chan_data = 4'h0;
    logic       mux_dout;
    logic       sel_0, sel_1, en, busy, sample_vld, sample_bit;
    logic [1:0] sample_ch;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0] ch;
        logic       b;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign mux_dout = en ? 1'b0 : chan_data[{sel_1, sel_0}];

    selector_scan_ctrl #(.DWELL_W(8), .BLANK_CYC(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .ch_mask    (ch_mask),
        .dwell      (dwell),
        .mux_dout   (mux_dout),
        .sel_0      (sel_0),
        .sel_1      (sel_1),
        .en         (en),
        .busy       (busy),
        .sample_vld (sample_vld),
        .sample_bit (sample_bit),
        .sample_ch  (sample_ch)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ch(input int ch);
        exp_t e;
        e.ch = 2'(ch);
        e.b  = chan_data[2'(ch)];
        exp_q.push_back(e);
    endtask

    task automatic start_scan(input logic [3:0] m, input logic [7:0] d);
        @(negedge clk);
        ch_mask = m;
        dwell   = d;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Returns on the negedge where en has just fallen with the given channel selected.
    task automatic wait_entry(input int ch);
        logic prev;
        int   n;
        int   done;
        prev = en;
        n    = 0;
        done = 0;
        while (done == 0 && n < 2000) begin
            @(negedge clk);
            n++;
            if (!en && prev && {sel_1, sel_0} == 2'(ch)) done = 1;
            prev = en;
        end
        chk("dwell_entry_reached", done, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", int'(busy), 0);
    endtask

    initial begin
        int lows;
        int vlds;
        int run;

        // Scoreboard monitor: pops one expectation per sample strobe.
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n && sample_vld) begin
                        chk("sample_expected", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk("sample_ch", int'(sample_ch), int'(e.ch));
                            chk("sample_bit", int'(sample_bit), int'(e.b));
                        end
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_sel", int'({sel_1, sel_0}), 0);
        chk("rst_en", int'(en), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_vld", int'(sample_vld), 0);
        chk("rst_bit", int'(sample_bit), 0);
        chk("rst_ch", int'(sample_ch), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full mask, dwell 3: period 4, samples 0,1,2,3,0
        chan_data = 4'b0110;
        push_ch(0); push_ch(1); push_ch(2); push_ch(3); push_ch(0);
        start_scan(4'b1111, 8'd3);
        chk("t2_busy", int'(busy), 1);
        chk("t2_blank_en", int'(en), 1);
        chk("t2_first_sel", int'({sel_1, sel_0}), 0);
        @(negedge clk);
        chk("t2_latency_en", int'(en), 0);
        lows = 0;
        vlds = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!en) lows++;
            if (sample_vld) vlds++;
        end
        chk("t2_en_low_cycles", lows, 12);
        chk("t2_vld_count", vlds, 4);
        pulse_stop();
        wait_idle();
        chk("t2_idle_en", int'(en), 1);

        // Mask 1010 with dout following sel_0: channels 1,3,1,3 all sampling 1
        chan_data = 4'b1010;
        push_ch(1); push_ch(3); push_ch(1); push_ch(3);
        start_scan(4'b1010, 8'd2);
        wait_entry(1); wait_entry(3); wait_entry(1); wait_entry(3);
        pulse_stop();
        wait_idle();

        // Single channel 2 repeats
        chan_data = 4'b0100;
        push_ch(2); push_ch(2); push_ch(2);
        start_scan(4'b0100, 8'd2);
        wait_entry(2); wait_entry(2); wait_entry(2);
        pulse_stop();
        wait_idle();

        // dwell 0 behaves as 1: en low one cycle in every two
        chan_data = 4'b0001;
        push_ch(0); push_ch(1); push_ch(0); push_ch(1); push_ch(0);
        start_scan(4'b0011, 8'd0);
        @(negedge clk);
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!en) lows++;
        end
        chk("t4_dwell0_low", lows, 4);
        pulse_stop();
        wait_idle();

        // dwell 255: one unbroken low run of 255, then stop during blanking
        push_ch(0);
        start_scan(4'b0001, 8'd255);
        wait_entry(0);
        run = 1;
        while (!en && run < 300) begin
            @(negedge clk);
            if (!en) run++;
        end
        chk("t4_dwell255_run", run, 255);
        pulse_stop();
        chk("t5_blank_stop_busy", int'(busy), 0);
        chk("t5_blank_stop_en", int'(en), 1);

        // Stop mid-dwell on channel 2: its sample is still emitted
        chan_data = 4'b0100;
        push_ch(0); push_ch(1); push_ch(2);
        start_scan(4'b1111, 8'd4);
        wait_entry(2);
        @(negedge clk);
        pulse_stop();
        wait_idle();
        chk("t5_dwell_stop_en", int'(en), 1);

        // Start with empty mask is ignored
        start_scan(4'b0000, 8'd1);
        @(negedge clk);
        chk("t6_mask0_busy", int'(busy), 0);

        // start and stop together: stop wins
        @(negedge clk);
        ch_mask = 4'b1111;
        dwell   = 8'd1;
        start   = 1'b1;
        stop    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        stop    = 1'b0;
        chk("t6_start_stop_busy", int'(busy), 0);
        @(negedge clk);
        chk("t6_start_stop_en", int'(en), 1);

        // Mask cleared mid-scan: current sample emitted, then IDLE
        chan_data = 4'b0011;
        push_ch(0);
        start_scan(4'b0011, 8'd3);
        wait_entry(0);
        ch_mask = 4'b0000;
        wait_idle();
        chk("t6_maskclr_en", int'(en), 1);
        repeat (6) @(negedge clk);
        chk("t6_maskclr_stays_idle", int'(busy), 0);

        // Reset mid-dwell: immediate reset values, no sample afterwards
        chan_data = 4'b0000;
        push_ch(0);
        start_scan(4'b1111, 8'd5);
        wait_entry(1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_en", int'(en), 1);
        chk("t1_rst_sel", int'({sel_1, sel_0}), 0);
        chk("t1_rst_busy", int'(busy), 0);
        chk("t1_rst_vld", int'(sample_vld), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t1_post_rst_busy", int'(busy), 0);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
